uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver, 8N1 (optional parity), receive side of the uart_tx link.
//   Samples the Uart_RX pin at mid-bit with a baud-divisor counter and delivers bytes over a valid/ready handshake.
//   Flags framing errors, overrun and (optionally) parity errors.
//   Sits between the board RX pin and the consumer logic (command parser / loopback).
// PARAMETERS
//   CLOCK_FREQUENCY  27000000  system clock in Hz
//   BAUD_RATE        115200    line rate in bit/s
//   BAUD_DIVISOR     CLOCK_FREQUENCY/BAUD_RATE (=234)  clocks per bit, integer truncation
//   PARITY_ODD       0         0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst_n       in   1  asynchronous, active-low reset
//   rx          in   1  serial line from pin, idle high, asynchronous to clk
//   data        out  8  received byte, stable while valid=1
//   valid       out  1  byte available; held until accepted
//   ready       in   1  consumer accepts byte when valid&&ready on a posedge
//   busy        out  1  1 while a frame is being received (state != IDLE)
//   frame_err   out  1  one-cycle pulse: stop bit sampled 0
//   parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 without UART_RX_PARITY_EN)
//   overrun     out  1  one-cycle pulse: new byte completed while valid=1 and ready=0
// BEHAVIOUR
//   - Reset: data=0, valid=0, busy=0, all error pulses 0, state=IDLE, synchroniser flops=1, counters=0.
//   - rx passes a 2-flop synchroniser (rx_s); all decisions use rx_s only (2-cycle input latency).
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or BREAK).
//   - IDLE: rx_s==0 -> START, bit counter loaded BAUD_DIVISOR/2-1 (mid-bit alignment).
//   - START: at counter==0 sample rx_s; 1 = glitch -> IDLE, no flags; 0 -> DATA, counter=BAUD_DIVISOR-1.
//   - DATA: 8 samples at counter==0, LSB first into shift reg; after bit 7 -> PARITY (if enabled) else STOP.
//   - STOP: sample at counter==0. 1 -> byte complete, IDLE next cycle. 0 -> frame_err pulse, byte discarded, -> BREAK.
//   - BREAK: wait for rx_s==1, then IDLE (no new start detected while line held low).
//   - Completion: data<=byte, valid<=1 one cycle after stop sample. If valid&&!ready at that cycle:
//     overrun pulse, new byte dropped, old data/valid retained.
//   - valid&&ready in same cycle as completion: old byte consumed, new byte loaded, valid stays 1, no overrun.
//   - valid&&ready otherwise: valid<=0 next cycle; data holds last value.
//   - Error pulses are exactly one clk wide; never asserted together with a valid rising for that frame.
//   - Counter width $clog2(BAUD_DIVISOR); counts down, reload on 0; no wrap past 0.
//   - Reset asserted mid-frame: immediate return to reset values; partial byte lost, no flags.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: PARITY state after DATA samples a 9th bit; expected = ^byte ^ PARITY_ODD;
//     mismatch -> parity_err pulse at completion and byte discarded (valid unchanged); stop still checked.
//   UART_RX_PARITY_EN undefined: no PARITY state, 8N1 framing, parity_err tied 0.
// STRUCTURE
//   uart_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP/BREAK), baud-divisor function,
//     CLOCK_FREQUENCY/BAUD_RATE defaults shared with uart_tx.
//   Sub-module uart_rx_sync: 2-flop synchroniser, reset-to-1, reused for any async pin input.
//   Top holds FSM, bit counter, baud counter, shift register, output register.
// TESTING
//   1. Send 0x55 8N1 at 234 clk/bit, ready=1 -> valid pulse 1 cycle, data=0x55, no error pulses.
//   2. Send 0xA3 with ready=0, then 0x3C -> data stays 0xA3, valid=1, overrun pulses once at 0x3C stop.
//   3. Send 0x41 with stop bit forced 0, line held low 1000 clk -> frame_err once, valid stays 0,
//      busy until line returns high; following 0x42 received correctly.
//   4. rx low glitch of 50 clk in IDLE -> returns to IDLE, valid=0, no flags.
//   5. Drive rst_n low at bit 4 of 0xFF, release, send 0x0F -> only 0x0F delivered.
//   6. With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 -> valid; parity 0 -> parity_err, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding, line defaults and baud-divisor helper.
package uart_pkg;

  localparam int CLOCK_FREQUENCY_DEFAULT = 27_000_000;
  localparam int BAUD_RATE_DEFAULT       = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Clocks per bit; integer truncation.
  function automatic int baud_divisor(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - Received-byte valid/ready handshake bundle.
interface uart_rx_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - Two-flop synchroniser for an asynchronous pin, resets to 1.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and valid/ready output.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEFAULT,
  parameter int BAUD_RATE       = BAUD_RATE_DEFAULT,
  parameter int BAUD_DIVISOR    = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD      = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  uart_rx_if.master stream,
  output logic     busy,
  output logic     frame_err,
  output logic     parity_err,
  output logic     overrun
);

  localparam int CW = (BAUD_DIVISOR > 2) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIVISOR - 1);

  uart_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          complete;
  logic          rx_s;
  logic          tick;

`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx),
    .sync_out (rx_s)
  );

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      complete     <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      stream.data  <= '0;
      stream.valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      complete  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      // Counter parks at zero; any reload below overrides the decrement.
      if (!tick) baud_cnt <= baud_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            baud_cnt <= HALF_LOAD;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ST_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift    <= {rx_s, shift[7:1]};
            baud_cnt <= FULL_LOAD;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            par_bit  <= rx_s;
            baud_cnt <= FULL_LOAD;
            state    <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              complete <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Hold off start detection until the line has gone idle again.
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (stream.valid && stream.ready) stream.valid <= 1'b0;

      if (complete) begin
`ifdef UART_RX_PARITY_EN
        if (par_bit != (^shift ^ PARITY_ODD)) par_err_q <= 1'b1;
        else
`endif
        if (stream.valid && !stream.ready) begin
          overrun <= 1'b1;
        end else begin
          stream.data  <= shift;
          stream.valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DIV = baud_divisor(CLOCK_FREQUENCY_DEFAULT, BAUD_RATE_DEFAULT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic busy, frame_err, parity_err, overrun;

  uart_rx_if bus ();

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .stream     (bus),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_frame = 0, n_par = 0, n_ovr = 0, n_rise = 0, n_valid_cycles = 0;
  logic [7:0] got_q[$];
  logic valid_d = 1'b0;

  always @(negedge clk) begin
    if (frame_err) n_frame++;
    if (parity_err) n_par++;
    if (overrun) n_ovr++;
    if (bus.valid && !valid_d) n_rise++;
    if (bus.valid) n_valid_cycles++;
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    valid_d = bus.valid;
  end

  // Reference model: consumer-visible bytes and expected pulse counts per frame.
  logic [7:0] exp_q[$];
  int   exp_frame = 0, exp_par = 0, exp_ovr = 0;
  bit   m_has = 1'b0;
  logic [7:0] m_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit r);
    bus.ready = r;
    if (r && m_has) begin
      exp_q.push_back(m_byte);
      m_has = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip);
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    idle(DIV);
`endif
    rx = stop_v;
    idle(DIV);
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_v, input bit par_flip);
    bit par_ok;
    par_ok = !par_flip;
`ifndef UART_RX_PARITY_EN
    par_ok = 1'b1;
`endif
    send_frame(b, stop_v, par_flip);
    if (!stop_v) exp_frame++;
    else if (!par_ok) exp_par++;
    else if (m_has && !bus.ready) exp_ovr++;
    else if (bus.ready) exp_q.push_back(b);
    else begin
      m_has  = 1'b1;
      m_byte = b;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_frame_err"}, n_frame, exp_frame);
    check({tag, "_parity_err"}, n_par, exp_par);
    check({tag, "_overrun"}, n_ovr, exp_ovr);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.ready = 1'b0;
    idle(5);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    idle(5);

    // 0x55 with consumer ready: single one-cycle valid, no flags
    set_ready(1'b1);
    frame(8'h55, 1'b1, 1'b0);
    idle(200);
    check("t1_rise", n_rise, 1);
    check("t1_valid_cycles", n_valid_cycles, 1);
    check("t1_busy", busy, 0);
    check("t1_data_hold", bus.data, 8'h55);
    check_model("t1");

    // Overrun: held byte survives a second completion
    set_ready(1'b0);
    frame(8'hA3, 1'b1, 1'b0);
    idle(100);
    frame(8'h3C, 1'b1, 1'b0);
    idle(100);
    check("t2_data", bus.data, 8'hA3);
    check("t2_valid", bus.valid, 1);
    set_ready(1'b1);
    idle(3);
    check("t2_valid_drop", bus.valid, 0);
    check_model("t2");

    // Framing error followed by long break, then a clean byte
    frame(8'h41, 1'b0, 1'b0);
    idle(1000);
    check("t3_busy_break", busy, 1);
    check("t3_valid", bus.valid, 0);
    rx = 1'b1;
    idle(10);
    check("t3_busy_idle", busy, 0);
    idle(100);
    frame(8'h42, 1'b1, 1'b0);
    idle(100);
    check_model("t3");

    // Short low glitch is rejected at the start-bit sample
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(10);
    check("t4_busy_glitch", busy, 1);
    idle(200);
    check("t4_busy_after", busy, 0);
    check("t4_valid", bus.valid, 0);
    check_model("t4");

    // Reset mid-frame discards the partial byte
    rx = 1'b0;
    idle(DIV);
    rx = 1'b1;
    idle(DIV * 4 + DIV / 2);
    rst_n = 1'b0;
    idle(3);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", bus.valid, 0);
    check("t5_rst_data", bus.data, 0);
    rst_n = 1'b1;
    idle(DIV * 6);
    frame(8'h0F, 1'b1, 1'b0);
    idle(100);
    check_model("t5");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    idle(100);
    frame(8'h07, 1'b1, 1'b1);
    idle(100);
    check_model("t6");
`endif

    // Randomised frames, consumer readiness and line faults
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      bit stop_v, pflip;
      b      = 8'($urandom);
      stop_v = ($urandom_range(0, 5) != 0);
      pflip  = ($urandom_range(0, 4) == 0);
      set_ready(1'($urandom_range(0, 1)));
      frame(b, stop_v, pflip);
      if (!stop_v) begin
        idle($urandom_range(0, 300));
        rx = 1'b1;
      end
      idle($urandom_range(20, 200));
    end
    set_ready(1'b1);
    idle(5);
    check_model("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
